// File: rtl/demux8_hold.sv
// Registered 1-to-8 demultiplexer with per-channel holding registers.
// Each channel holds its word until acknowledged; refused writes raise a sticky drop flag.
module demux8_hold (
    input  logic        clk,
    input  logic        rst,
    input  logic        iWe,
    input  logic [2:0]  S,
    input  logic [31:0] D,
    output logic        oReady,
    output logic [31:0] oQ0,
    output logic [31:0] oQ1,
    output logic [31:0] oQ2,
    output logic [31:0] oQ3,
    output logic [31:0] oQ4,
    output logic [31:0] oQ5,
    output logic [31:0] oQ6,
    output logic [31:0] oQ7,
    output logic [7:0]  oValid,
    input  logic [7:0]  iAck,
    output logic [3:0]  oCount,
    output logic        oDrop
);

    logic [31:0] data_r [8];
    logic [7:0]  valid_r;
    logic [3:0]  count_r;
    logic        drop_r;

    logic        ready_s;
    logic        accept_s;
    logic        refuse_s;
    logic [7:0]  wr_onehot_s;
    logic [7:0]  valid_next_s;
    logic [3:0]  count_next_s;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // Decode the write select into a one-hot channel mask.
    always_comb begin
        wr_onehot_s = 8'h00;
        case (S)
            3'd0:    wr_onehot_s = 8'h01;
            3'd1:    wr_onehot_s = 8'h02;
            3'd2:    wr_onehot_s = 8'h04;
            3'd3:    wr_onehot_s = 8'h08;
            3'd4:    wr_onehot_s = 8'h10;
            3'd5:    wr_onehot_s = 8'h20;
            3'd6:    wr_onehot_s = 8'h40;
            3'd7:    wr_onehot_s = 8'h80;
            default: wr_onehot_s = 8'h00;
        endcase
    end

    // Acceptance and next valid/count; a same-cycle ack frees the slot for the write.
    always_comb begin
        ready_s      = ((valid_r & wr_onehot_s) == 8'h00) || ((iAck & wr_onehot_s) != 8'h00);
        accept_s     = 1'b0;
        refuse_s     = 1'b0;
        valid_next_s = valid_r & ~iAck;
        if (iWe) begin
            if (ready_s) begin
                accept_s     = 1'b1;
                valid_next_s = (valid_r & ~iAck) | wr_onehot_s;
            end else begin
                refuse_s     = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
        end
        count_next_s = popcount8(valid_next_s);
    end

    // Holding registers, valid bits, occupancy and sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                data_r[k] <= 32'd0;
            end
            valid_r <= 8'h00;
            count_r <= 4'd0;
            drop_r  <= 1'b0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (accept_s && wr_onehot_s[k]) begin
                    data_r[k] <= D;
                end
            end
            valid_r <= valid_next_s;
            count_r <= count_next_s;
            if (refuse_s) begin
                drop_r <= 1'b1;
            end
        end
    end

    assign oReady = ready_s;
    assign oQ0    = data_r[0];
    assign oQ1    = data_r[1];
    assign oQ2    = data_r[2];
    assign oQ3    = data_r[3];
    assign oQ4    = data_r[4];
    assign oQ5    = data_r[5];
    assign oQ6    = data_r[6];
    assign oQ7    = data_r[7];
    assign oValid = valid_r;
    assign oCount = count_r;
    assign oDrop  = drop_r;

endmodule

// File: tb/tb_demux8_hold.sv
// Directed self-checking bench for demux8_hold.
module tb_demux8_hold;

    logic        clk;
    logic        rst;
    logic        iWe;
    logic [2:0]  S;
    logic [31:0] D;
    logic        oReady;
    logic [31:0] oQ0, oQ1, oQ2, oQ3, oQ4, oQ5, oQ6, oQ7;
    logic [7:0]  oValid;
    logic [7:0]  iAck;
    logic [3:0]  oCount;
    logic        oDrop;

    int checks   = 0;
    int failures = 0;

    demux8_hold dut (
        .clk(clk), .rst(rst), .iWe(iWe), .S(S), .D(D), .oReady(oReady),
        .oQ0(oQ0), .oQ1(oQ1), .oQ2(oQ2), .oQ3(oQ3),
        .oQ4(oQ4), .oQ5(oQ5), .oQ6(oQ6), .oQ7(oQ7),
        .oValid(oValid), .iAck(iAck), .oCount(oCount), .oDrop(oDrop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [2:0] sel, input logic [31:0] data);
        iWe = 1'b1;
        S   = sel;
        D   = data;
        tick();
        iWe = 1'b0;
    endtask

    initial begin
        rst = 1'b1; iWe = 1'b0; S = 3'd0; D = 32'd0; iAck = 8'h00;
        tick();
        rst = 1'b0;
        chk("reset_valid", {24'd0, oValid}, 32'h0000_0000);
        chk("reset_count", {28'd0, oCount}, 32'd0);
        chk("reset_drop",  {31'd0, oDrop},  32'd0);
        chk("reset_q7",    oQ7, 32'd0);
        chk("reset_ready", {31'd0, oReady}, 32'd1);

        // basic write
        write(3'd3, 32'hDEAD_BEEF);
        chk("wr_q3",    oQ3, 32'hDEAD_BEEF);
        chk("wr_valid", {24'd0, oValid}, 32'h0000_0008);
        chk("wr_count", {28'd0, oCount}, 32'd1);
        chk("wr_drop",  {31'd0, oDrop},  32'd0);
        chk("wr_q0",    oQ0, 32'd0);
        chk("wr_q4",    oQ4, 32'd0);

        // plain ack clears valid, keeps data
        iAck = 8'h08;
        tick();
        iAck = 8'h00;
        chk("ack_valid", {24'd0, oValid}, 32'h0000_0000);
        chk("ack_count", {28'd0, oCount}, 32'd0);
        chk("ack_q3",    oQ3, 32'hDEAD_BEEF);

        // fill all channels
        for (int i = 0; i < 8; i++) begin
            write(i[2:0], 32'h100 + i);
        end
        chk("fill_valid", {24'd0, oValid}, 32'h0000_00FF);
        chk("fill_count", {28'd0, oCount}, 32'd8);
        chk("fill_q3",    oQ3, 32'h103);
        chk("fill_q7",    oQ7, 32'h107);
        for (int i = 0; i < 8; i++) begin
            S = i[2:0];
            #1;
            chk("fill_ready", {31'd0, oReady}, 32'd0);
        end

        // refused write
        write(3'd5, 32'h0BAD);
        chk("ref_q5",    oQ5, 32'h105);
        chk("ref_count", {28'd0, oCount}, 32'd8);
        chk("ref_drop",  {31'd0, oDrop},  32'd1);
        repeat (5) tick();
        chk("ref_drop_sticky", {31'd0, oDrop}, 32'd1);

        // same-cycle ack and write on channel 2
        iAck = 8'h04; iWe = 1'b1; S = 3'd2; D = 32'hCAFE;
        #1;
        chk("aw_ready", {31'd0, oReady}, 32'd1);
        tick();
        iAck = 8'h00; iWe = 1'b0;
        chk("aw_q2",    oQ2, 32'h0000_CAFE);
        chk("aw_valid", {24'd0, oValid}, 32'h0000_00FF);
        chk("aw_count", {28'd0, oCount}, 32'd8);

        // drain upper half, then multi-ack with spurious bits
        iAck = 8'hF0;
        tick();
        chk("half_valid", {24'd0, oValid}, 32'h0000_000F);
        chk("half_count", {28'd0, oCount}, 32'd4);
        iAck = 8'hF3;
        tick();
        iAck = 8'h00;
        chk("multi_valid", {24'd0, oValid}, 32'h0000_000C);
        chk("multi_count", {28'd0, oCount}, 32'd2);
        chk("multi_q0",    oQ0, 32'h100);
        chk("multi_q1",    oQ1, 32'h101);
        chk("multi_q2",    oQ2, 32'h0000_CAFE);
        chk("multi_q6",    oQ6, 32'h106);
        chk("multi_drop",  {31'd0, oDrop}, 32'd1);

        // refill to full; accepted writes must not clear drop
        write(3'd0, 32'h200);
        write(3'd1, 32'h201);
        for (int i = 4; i < 8; i++) begin
            write(i[2:0], 32'h200 + i);
        end
        chk("refill_valid", {24'd0, oValid}, 32'h0000_00FF);
        chk("refill_count", {28'd0, oCount}, 32'd8);
        chk("refill_drop",  {31'd0, oDrop},  32'd1);

        // reset mid-operation with a concurrent write
        rst = 1'b1; iWe = 1'b1; S = 3'd0; D = 32'h1;
        tick();
        rst = 1'b0; iWe = 1'b0;
        chk("mrst_valid", {24'd0, oValid}, 32'h0000_0000);
        chk("mrst_count", {28'd0, oCount}, 32'd0);
        chk("mrst_drop",  {31'd0, oDrop},  32'd0);
        chk("mrst_q0",    oQ0, 32'd0);
        chk("mrst_q2",    oQ2, 32'd0);
        chk("mrst_q5",    oQ5, 32'd0);
        chk("mrst_ready", {31'd0, oReady}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
